// File: rtl/boa_mem_arbiter_pkg.sv
// Shared definitions for the boa data-memory arbiter: state encoding, port limits
// and the round-robin pointer helper.
package boa_mem_arbiter_pkg;

    localparam int unsigned ArbMaxPorts = 8;

    typedef enum logic [0:0] {
        ArbIdle,
        ArbLocked
    } arb_state_e;

    // Next round-robin start index; wraps to 0 so non-power-of-two counts stay in range.
    function automatic int unsigned arb_next_idx(input int unsigned idx, input int unsigned ports);
        return (idx + 1 >= ports) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/boa_mem_arbiter_if.sv
// Single-port data-memory bus: word address, byte write enables, read data returned
// one cycle after the accepting ready.
interface boa_mem_arbiter_if;

    logic        re;
    logic [3:0]  we;
    logic [31:2] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output re, we, addr, wdata,
        input  rdata, ready
    );

    modport slave (
        input  re, we, addr, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/boa_mem_arbiter_rr_pick.sv
// Combinational requester picker: first set request searching upward from a start
// index with wrap-around, or from index 0 when fixed priority is selected.
module boa_mem_arbiter_rr_pick #(
    parameter int unsigned Ports = 2
) (
    input  logic [Ports-1:0]                        req_i,
    input  logic [(Ports > 1 ? $clog2(Ports) : 1)-1:0] start_i,
    input  logic                                    fixed_prio_i,
    output logic [(Ports > 1 ? $clog2(Ports) : 1)-1:0] winner_o,
    output logic                                    valid_o
);

    localparam int unsigned IdxW = (Ports > 1) ? $clog2(Ports) : 1;

    int unsigned     base;
    int unsigned     idx;
    logic [IdxW-1:0] sel;

    always_comb begin
        base     = fixed_prio_i ? 0 : 32'(start_i);
        if (base >= Ports) begin
            base = 0;
        end
        idx      = 0;
        sel      = '0;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int unsigned i = 0; i < Ports; i++) begin
            idx = base + i;
            if (idx >= Ports) begin
                idx = idx - Ports;
            end
            sel = IdxW'(idx);
            if (!valid_o && req_i[sel]) begin
                valid_o  = 1'b1;
                winner_o = sel;
            end
        end
    end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Shares one data-memory bus between PORTS requesters; the grant is held across wait
// states and each read response is steered back to the port that issued it.
module boa_mem_arbiter
    import boa_mem_arbiter_pkg::*;
#(
    parameter int unsigned PORTS      = 2,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [PORTS-1:0]      req_re_i,
    input  logic [PORTS*4-1:0]    req_we_i,
    input  logic [PORTS*30-1:0]   req_addr_i,
    input  logic [PORTS*32-1:0]   req_wdata_i,
    output logic [PORTS-1:0]      req_ready_o,
    output logic [PORTS-1:0]      req_rvalid_o,
    output logic [31:0]           req_rdata_o,
    boa_mem_arbiter_if.master     bus
);

    localparam int unsigned IdxW = $clog2(PORTS);

    if (PORTS < 2 || PORTS > ArbMaxPorts) begin : g_ports_check
        $error("boa_mem_arbiter: PORTS must be 2..8");
    end

    arb_state_e      state_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] rr_ptr_q;
    logic [IdxW-1:0] resp_port_q;
    logic            resp_pend_q;

    logic [PORTS-1:0] active;
    logic [IdxW-1:0]  winner;
    logic [IdxW-1:0]  grant;
    logic             any_req;
    logic             drive_en;
    logic             complete;
    logic             g_re;
    logic [3:0]       g_we;
    logic             is_read;

    always_comb begin
        for (int p = 0; p < int'(PORTS); p++) begin
            active[p] = req_re_i[p] | (|req_we_i[4*p +: 4]);
        end
    end

    boa_mem_arbiter_rr_pick #(
        .Ports (PORTS)
    ) u_pick (
        .req_i        (active),
        .start_i      (rr_ptr_q),
        .fixed_prio_i (FIXED_PRIO),
        .winner_o     (winner),
        .valid_o      (any_req)
    );

    // While locked the owner keeps the bus even if its request looks idle.
    always_comb begin
        grant     = (state_q == ArbLocked) ? owner_q : winner;
        drive_en  = rst_ni & ((state_q == ArbLocked) | any_req);
        g_re      = req_re_i[grant];
        g_we      = req_we_i[4*grant +: 4];
        is_read   = g_re & ~(|g_we);
        bus.re    = drive_en & g_re;
        bus.we    = drive_en ? g_we : 4'b0000;
        bus.addr  = req_addr_i[30*grant +: 30];
        bus.wdata = req_wdata_i[32*grant +: 32];
        complete  = drive_en & bus.ready;

        req_ready_o        = '0;
        req_ready_o[grant] = complete;

        req_rvalid_o              = '0;
        req_rvalid_o[resp_port_q] = resp_pend_q;
    end

    assign req_rdata_o = bus.rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ArbIdle;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            resp_port_q <= '0;
            resp_pend_q <= 1'b0;
        end else begin
            resp_pend_q <= complete & is_read;
            if (complete) begin
                rr_ptr_q <= IdxW'(arb_next_idx(32'(grant), PORTS));
                if (is_read) begin
                    resp_port_q <= grant;
                end
            end
            unique case (state_q)
                ArbIdle: begin
                    if (any_req && !bus.ready) begin
                        state_q <= ArbLocked;
                        owner_q <= winner;
                    end
                end
                ArbLocked: begin
                    if (bus.ready) begin
                        state_q <= ArbIdle;
                    end
                end
                default: state_q <= ArbIdle;
            endcase
        end
    end

endmodule

// File: doc/boa_mem_arbiter.md
Name: boa_mem_arbiter

Overview:
- Shares one boa_mem_bus data-memory port between PORTS requesters, e.g. the MEM stage memory helper, a debug/DMA master, and a future cache refill engine.
- Grants the bus by round-robin or fixed priority, and holds the grant for the whole of an un-acknowledged transaction.
- Steers each registered read-data response back to the requester that issued it.
- Sits between the requesters and the single dbus going to the memory fabric.

Parameters:
- PORTS, 2, number of requesters (2..8).
- FIXED_PRIO, 0, 1 = fixed priority with port 0 highest; 0 = round-robin.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  reset, asynchronous, active-low.
- req_re  in  PORTS  per-port read enable.
- req_we  in  PORTS*4  per-port byte write enables; port i uses bits [4i+3:4i].
- req_addr  in  PORTS*30  per-port word address [31:2].
- req_wdata  in  PORTS*32  per-port write data.
- req_ready  out  PORTS  per-port transaction-accepted strobe.
- req_rvalid  out  PORTS  per-port read-data-valid pulse.
- req_rdata  out  32  read data, broadcast to all ports; qualified by req_rvalid.
- bus  boa_mem_bus.CPU  -  shared memory bus (re, we[3:0], addr[31:2], wdata, rdata, ready).

Behaviour:
- Bus protocol
  - A transaction is active when re or any we bit is set.
  - It completes in the cycle where bus.ready=1.
  - Read data appears on bus.rdata in the cycle after completion.
- Requester obligation
  - A requester holds re/we/addr/wdata stable from assertion until its req_ready.
  - Requests asserting both re and we are illegal. They are forwarded unchanged, and no rvalid is returned for them.
- States
  - IDLE: no lock.
  - LOCKED: owner register valid. Entered when a granted transaction sees bus.ready=0.
- Grant
  - IDLE: combinationally pick a winner among active ports and drive its signals to bus in the same cycle (zero added latency).
    - Round-robin: search starts at rr_ptr and wraps modulo PORTS.
    - FIXED_PRIO=1: lowest index wins.
  - LOCKED: the owner is driven regardless of other requests. Competing requests are ignored.
- Transitions
  - IDLE→LOCKED: winner active and bus.ready=0; owner <= winner.
  - LOCKED→IDLE: bus.ready=1.
  - IDLE with winner and bus.ready=1: completes in one cycle and stays IDLE.
- Completion
  - req_ready[g]=bus.ready for the driven port g only; all other req_ready are 0.
  - rr_ptr <= (g+1) mod PORTS on completion. It never changes otherwise.
- Read response
  - On completion of a read, resp_port <= g and resp_pend <= 1. Otherwise resp_pend <= 0.
  - req_rvalid = one-hot(resp_port) & resp_pend, i.e. one cycle after req_ready.
  - req_rdata = bus.rdata, unregistered.
- No active port: bus.re=0, bus.we=0, addr/wdata don't-care; state stays IDLE.
- Back-to-back
  - A port completing in cycle t may be re-granted at t+1 only if no other port is active (round-robin).
  - A read response and the next grant may overlap in the same cycle.
- Reset (rst=0, asynchronous)
  - State IDLE, owner cleared, rr_ptr=0, resp_pend=0.
  - Outputs while rst=0: req_ready=0, req_rvalid=0, bus.re=0, bus.we=0.
  - Reset mid-transaction abandons it; no ready or rvalid is issued afterwards for it.
- Width rules
  - owner, resp_port and rr_ptr are $clog2(PORTS) bits wide.
  - rr_ptr wraps from PORTS-1 to 0.
  - For non-power-of-two PORTS, out-of-range index values are never produced.

Decomposition:
- Shared package (boa_defines.svh):
  - ARB_MAX_PORTS=8.
  - Arbiter state enum {ARB_IDLE, ARB_LOCKED}.
- Sub-module boa_rr_pick (combinational):
  - Inputs: request vector, start pointer, fixed-priority flag.
  - Outputs: winner index, any-valid.
  - Reusable later for an instruction/data bus arbiter.

Test Plan:
- PORTS=2, round-robin, bus.ready tied 1:
  - Port0 and port1 both read every cycle.
  - Grants alternate 0,1,0,1; each req_rvalid pulses one cycle after its req_ready.
  - req_rdata equals the memory word for the correct address.
- Wait-state lock:
  - Port1 writes we=4'b1111 to 0x100 (addr=0x40); bus.ready held low for 3 cycles.
  - Port0 requests in cycle 2.
  - bus stays on port1 until ready; port0 is granted the cycle after.
- Fixed priority:
  - FIXED_PRIO=1, PORTS=4, ports 1,2,3 request continuously.
  - Port1 wins every cycle; ports 2 and 3 starve.
- Reset mid-transaction:
  - Port0 read pending with bus.ready=0; rst pulsed low asynchronously.
  - bus.re drops immediately, no req_rvalid follows, rr_ptr=0 after release.
- Wrap and idle:
  - PORTS=3: port2 completes, then port0 and port2 request together.
  - Port0 wins (pointer wrapped to 0).
  - With no requests: bus.re/we=0 and no state change.
